// File: rtl/y_sram_if.sv
// Y SRAM access bus: the arbiter (master) drives addresses and write data,
// the storage responder (slave) returns registered read data and readiness.
interface y_sram_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256
);
  logic [ADDR_W-1:0] in_yReadAddress1;
  logic [ADDR_W-1:0] in_yReadAddress2;
  logic              in_yWriteEnable;
  logic [ADDR_W-1:0] in_yWriteAddress;
  logic [DATA_W-1:0] in_writeData;
  logic [DATA_W-1:0] op_readData1;
  logic [DATA_W-1:0] op_readData2;
  logic              op_readValid1;
  logic              op_readValid2;
  logic              op_ready;

  modport master (
    output in_yReadAddress1, in_yReadAddress2, in_yWriteEnable,
           in_yWriteAddress, in_writeData,
    input  op_readData1, op_readData2, op_readValid1, op_readValid2, op_ready
  );

  modport slave (
    input  in_yReadAddress1, in_yReadAddress2, in_yWriteEnable,
           in_yWriteAddress, in_writeData,
    output op_readData1, op_readData2, op_readValid1, op_readValid2, op_ready
  );
endinterface

// File: rtl/y_sram_resp.sv
// Y SRAM responder: 2047-word storage with one write port and two
// registered read ports. The all-ones address is the parked bus value and
// has no backing entry. After reset an optional sweep zero-fills storage
// before op_ready rises.
module y_sram_resp #(
  parameter int                ADDR_W        = 11,
  parameter int                DATA_W        = 256,
  parameter logic [ADDR_W-1:0] NULL_ADDR     = {ADDR_W{1'b1}},
  parameter bit                INIT_ON_RESET = 1'b1
) (
  input logic      clk,
  input logic      reset,
  y_sram_if.slave  bus
);

  // Storable entries sit below the parked address.
  localparam int                DEPTH     = int'(NULL_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = NULL_ADDR - ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_INIT        = 2'd0,
    ST_RUN_PENDING = 2'd1,
    ST_RUN         = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] initCount;

  logic              opReady;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;

  logic [DATA_W-1:0] rd1Data;
  logic [DATA_W-1:0] rd2Data;
  logic              rd1Valid;
  logic              rd2Valid;

  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              readValid1;
  logic              readValid2;

  logic [DATA_W-1:0] mem [DEPTH];

  // State register: reset selects the sweep or the one-cycle pending state.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT_ON_RESET ? ST_INIT : ST_RUN_PENDING;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: sweep ends on the edge that clears the last entry.
  // NOTE: defaulting every comb output first keeps unlisted paths from
  // inferring latches.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_INIT:        if (initCount == LAST_ADDR) nextState = ST_RUN;
      ST_RUN_PENDING: nextState = ST_RUN;
      ST_RUN:         nextState = ST_RUN;
      default:        nextState = ST_INIT;
    endcase
  end

  // Output logic: readiness and the single memory write port mux.
  always_comb begin
    opReady  = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWData = '0;
    unique case (state)
      ST_INIT: begin
        memWe   = 1'b1;
        memAddr = initCount;
      end
      ST_RUN: begin
        opReady  = 1'b1;
        memWe    = bus.in_yWriteEnable && (bus.in_yWriteAddress != NULL_ADDR);
        memAddr  = bus.in_yWriteAddress;
        memWData = bus.in_writeData;
      end
      default: ;
    endcase
  end

  // Sweep counter: restarts on every reset, advances only while sweeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      initCount <= '0;
    end else if (state == ST_INIT) begin
      initCount <= initCount + ADDR_W'(1);
    end
  end

  // Storage write port; a write coinciding with reset is dropped.
  // NOTE: the array itself has no reset branch so it maps onto RAM; the
  // sweep provides the zero-fill instead.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem[memAddr] <= memWData;
    end
  end

  // Read lookup with write-first bypass, evaluated per port.
  always_comb begin
    rd1Data  = '0;
    rd1Valid = 1'b0;
    rd2Data  = '0;
    rd2Valid = 1'b0;
    if (bus.in_yReadAddress1 != NULL_ADDR) begin
      rd1Valid = 1'b1;
      rd1Data  = (memWe && memAddr == bus.in_yReadAddress1)
               ? memWData : mem[bus.in_yReadAddress1];
    end
    if (bus.in_yReadAddress2 != NULL_ADDR) begin
      rd2Valid = 1'b1;
      rd2Data  = (memWe && memAddr == bus.in_yReadAddress2)
               ? memWData : mem[bus.in_yReadAddress2];
    end
  end

  // Read output registers: only served in RUN, otherwise forced to zero.
  always_ff @(posedge clk) begin
    if (reset || state != ST_RUN) begin
      readData1  <= '0;
      readData2  <= '0;
      readValid1 <= 1'b0;
      readValid2 <= 1'b0;
    end else begin
      readData1  <= rd1Data;
      readData2  <= rd2Data;
      readValid1 <= rd1Valid;
      readValid2 <= rd2Valid;
    end
  end

  assign bus.op_readData1  = readData1;
  assign bus.op_readData2  = readData2;
  assign bus.op_readValid1 = readValid1;
  assign bus.op_readValid2 = readValid2;
  assign bus.op_ready      = opReady;

endmodule

// File: tb/tb_y_sram_resp.sv
// Directed bench for y_sram_resp: init sweep timing, write/read, bypass,
// parked address handling, reset during the sweep and ignored inputs.
module tb_y_sram_resp;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 256;
  localparam int SWEEP  = 2047;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  y_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  y_sram_resp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NULL_ADDR(11'h7ff),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and land on the following falling edge for sampling.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs;
    bus.in_yReadAddress1 = 11'h7ff;
    bus.in_yReadAddress2 = 11'h7ff;
    bus.in_yWriteEnable  = 1'b0;
    bus.in_yWriteAddress = 11'h000;
    bus.in_writeData     = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    assertCount++;
    if (bus.op_ready !== 1'b0) begin
      failCount++;
      $display("FAIL reset_ready: got %b expected 0", bus.op_ready);
    end
    assertCount++;
    if (bus.op_readData1 !== '0 || bus.op_readData2 !== '0) begin
      failCount++;
      $display("FAIL reset_data: got %h / %h expected 0", bus.op_readData1, bus.op_readData2);
    end
    assertCount++;
    if (bus.op_readValid1 !== 1'b0 || bus.op_readValid2 !== 1'b0) begin
      failCount++;
      $display("FAIL reset_valid: got %b%b expected 00", bus.op_readValid1, bus.op_readValid2);
    end
  endtask

  task automatic test_init_timing;
    int n;
    reset = 1'b0;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    assertCount++;
    if (n != SWEEP) begin
      failCount++;
      $display("FAIL init_ready_delay: got %0d cycles not ready expected %0d", n, SWEEP);
    end
    bus.in_yReadAddress1 = 11'h010;
    tick();
    assertCount++;
    if (bus.op_readData1 !== '0 || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL init_read_zero: got %h v=%b expected 0 v=1", bus.op_readData1, bus.op_readValid1);
    end
  endtask

  task automatic test_write_read;
    logic [DATA_W-1:0] pat;
    pat = {32{8'hA5}};
    bus.in_yWriteEnable  = 1'b1;
    bus.in_yWriteAddress = 11'h010;
    bus.in_writeData     = pat;
    bus.in_yReadAddress1 = 11'h011;
    tick();
    bus.in_yWriteEnable  = 1'b0;
    bus.in_yReadAddress1 = 11'h010;
    bus.in_yReadAddress2 = 11'h011;
    tick();
    assertCount++;
    if (bus.op_readData1 !== pat || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL write_read: got %h v=%b expected %h v=1", bus.op_readData1, bus.op_readValid1, pat);
    end
    assertCount++;
    if (bus.op_readData2 !== '0 || bus.op_readValid2 !== 1'b1) begin
      failCount++;
      $display("FAIL write_neighbour: got %h v=%b expected 0 v=1", bus.op_readData2, bus.op_readValid2);
    end
  endtask

  task automatic test_bypass;
    logic [DATA_W-1:0] val;
    val = 256'h1234;
    bus.in_yWriteEnable  = 1'b1;
    bus.in_yWriteAddress = 11'h020;
    bus.in_writeData     = val;
    bus.in_yReadAddress1 = 11'h020;
    bus.in_yReadAddress2 = 11'h020;
    tick();
    bus.in_yWriteEnable = 1'b0;
    assertCount++;
    if (bus.op_readData1 !== val || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL bypass_port1: got %h v=%b expected %h v=1", bus.op_readData1, bus.op_readValid1, val);
    end
    assertCount++;
    if (bus.op_readData2 !== val || bus.op_readValid2 !== 1'b1) begin
      failCount++;
      $display("FAIL bypass_port2: got %h v=%b expected %h v=1", bus.op_readData2, bus.op_readValid2, val);
    end
  endtask

  // Writes four words on consecutive cycles while port 1 reads the previous
  // address and port 2 reads the address being written.
  task automatic test_back_to_back;
    logic [ADDR_W-1:0] addr [4];
    logic [DATA_W-1:0] data [4];
    addr[0] = 11'h100; data[0] = {8{32'hDEADBEEF}};
    addr[1] = 11'h101; data[1] = {8{32'h01234567}};
    addr[2] = 11'h102; data[2] = {8{32'h89ABCDEF}};
    addr[3] = 11'h103; data[3] = {8{32'h0F0F00F0}};
    for (int i = 0; i < 4; i++) begin
      bus.in_yWriteEnable  = 1'b1;
      bus.in_yWriteAddress = addr[i];
      bus.in_writeData     = data[i];
      bus.in_yReadAddress2 = addr[i];
      bus.in_yReadAddress1 = (i == 0) ? 11'h7ff : addr[i-1];
      tick();
      assertCount++;
      if (bus.op_readData2 !== data[i] || bus.op_readValid2 !== 1'b1) begin
        failCount++;
        $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, bus.op_readData2, data[i]);
      end
      if (i > 0) begin
        assertCount++;
        if (bus.op_readData1 !== data[i-1] || bus.op_readValid1 !== 1'b1) begin
          failCount++;
          $display("FAIL b2b_prev[%0d]: got %h expected %h", i, bus.op_readData1, data[i-1]);
        end
      end
    end
    bus.in_yWriteEnable = 1'b0;
  endtask

  task automatic test_null_addr;
    logic [DATA_W-1:0] top;
    top = {64{4'h5}};
    bus.in_yWriteEnable  = 1'b1;
    bus.in_yWriteAddress = 11'h7ff;
    bus.in_writeData     = '1;
    bus.in_yReadAddress1 = 11'h7fe;
    bus.in_yReadAddress2 = 11'h7ff;
    tick();
    bus.in_yWriteEnable = 1'b0;
    assertCount++;
    if (bus.op_readData2 !== '0 || bus.op_readValid2 !== 1'b0) begin
      failCount++;
      $display("FAIL null_read: got %h v=%b expected 0 v=0", bus.op_readData2, bus.op_readValid2);
    end
    assertCount++;
    if (bus.op_readData1 !== '0 || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL null_no_alias_bypass: got %h v=%b expected 0 v=1", bus.op_readData1, bus.op_readValid1);
    end
    tick();
    assertCount++;
    if (bus.op_readData1 !== '0 || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL null_write_dropped: got %h v=%b expected 0 v=1", bus.op_readData1, bus.op_readValid1);
    end
    bus.in_yWriteEnable  = 1'b1;
    bus.in_yWriteAddress = 11'h7fe;
    bus.in_writeData     = top;
    tick();
    bus.in_yWriteEnable = 1'b0;
    tick();
    assertCount++;
    if (bus.op_readData1 !== top || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL top_entry: got %h v=%b expected %h v=1", bus.op_readData1, bus.op_readValid1, top);
    end
  endtask

  // Reset mid-run, then reset again 1000 cycles into the sweep while a
  // write and reads are held active; none of them may take effect.
  task automatic test_reset_mid_init;
    int n;
    int noisy;
    reset = 1'b1;
    tick();
    assertCount++;
    if (bus.op_ready !== 1'b0 || bus.op_readValid1 !== 1'b0 || bus.op_readData1 !== '0) begin
      failCount++;
      $display("FAIL run_reset: got rdy=%b v=%b d=%h expected 0 0 0", bus.op_ready, bus.op_readValid1, bus.op_readData1);
    end
    reset = 1'b0;
    bus.in_yWriteEnable  = 1'b1;
    bus.in_yWriteAddress = 11'h005;
    bus.in_writeData     = 256'hC0DE;
    bus.in_yReadAddress1 = 11'h005;
    bus.in_yReadAddress2 = 11'h005;
    noisy = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.op_ready !== 1'b0 || bus.op_readValid1 !== 1'b0 || bus.op_readValid2 !== 1'b0
          || bus.op_readData1 !== '0 || bus.op_readData2 !== '0) noisy++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 3000) begin
      if (bus.op_readValid1 !== 1'b0 || bus.op_readValid2 !== 1'b0
          || bus.op_readData1 !== '0 || bus.op_readData2 !== '0) noisy++;
      n++;
      tick();
    end
    assertCount++;
    if (n != SWEEP) begin
      failCount++;
      $display("FAIL reset_mid_init_delay: got %0d cycles not ready expected %0d", n, SWEEP);
    end
    assertCount++;
    if (noisy != 0) begin
      failCount++;
      $display("FAIL init_outputs_quiet: got %0d active cycles expected 0", noisy);
    end
    bus.in_yWriteEnable  = 1'b0;
    bus.in_yReadAddress1 = 11'h005;
    bus.in_yReadAddress2 = 11'h010;
    tick();
    assertCount++;
    if (bus.op_readData1 !== '0 || bus.op_readValid1 !== 1'b1) begin
      failCount++;
      $display("FAIL init_write_ignored: got %h v=%b expected 0 v=1", bus.op_readData1, bus.op_readValid1);
    end
    assertCount++;
    if (bus.op_readData2 !== '0 || bus.op_readValid2 !== 1'b1) begin
      failCount++;
      $display("FAIL resweep_cleared: got %h v=%b expected 0 v=1", bus.op_readData2, bus.op_readValid2);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    @(negedge clk);
    test_reset();
    test_init_timing();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_null_addr();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
